// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// start/busy/done handshake with kill, XLEN+1 cycle fixed latency.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   spec_val_q, spec_val_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              zero_q, zero_d;

  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] acc_neg, mul_full;
  logic [XLEN-1:0]   div_val, fix_res;

  always_comb begin
    a_sgn    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    b_sgn    = op[2] ? ~op[0] : ~op[1];
    a_neg    = a_sgn & a[XLEN-1];
    b_neg    = b_sgn & b[XLEN-1];
    a_mag    = a_neg ? '0 - a : a;
    b_mag    = b_neg ? '0 - b : b;
    div_zero = op[2] & (b == '0);
    div_ovf  = op[2] & ~op[0] & (a == MIN_NEG) & (b == '1);

    // acc holds {high, low}: product accumulator for multiply, {remainder, quotient} for divide
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_ge   = rem_sh >= {1'b0, dvs_q};
    div_rem  = rem_sh[XLEN-1:0] - dvs_q;

    acc_neg  = '0 - acc_q;
    mul_full = neg_q ? acc_neg : acc_q;
    div_val  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (spec_q)                fix_res = spec_val_q;
    else if (op_q[2])          fix_res = neg_q ? '0 - div_val : div_val;
    else if (op_q[1:0] == 2'b00) fix_res = mul_full[XLEN-1:0];
    else                       fix_res = mul_full[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    dvs_d      = dvs_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    res_d      = res_q;
    zero_d     = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start & ~kill) begin
          state_d    = S_RUN;
          busy_d     = 1'b1;
          cnt_d      = CNT_W'(XLEN);
          op_d       = op;
          neg_d      = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
          spec_d     = div_zero | div_ovf;
          spec_val_d = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
          acc_d      = {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
          dvs_d      = op[2] ? b_mag : a_mag;
        end
      end
      S_RUN: begin
        if (kill) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (op_q[2])
            acc_d = {(div_ge ? div_rem : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
          else
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!kill) begin
          done_d = 1'b1;
          res_d  = fix_res;
          zero_d = (fix_res == '0);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      dvs_q      <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      dvs_q      <= dvs_d;
      acc_q      <= acc_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a cycle model predicts accepts, busy, done
// timing and results; a second XLEN=8 instance covers parametrisation.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, zero;
  logic [31:0] result;

  logic        start8 = 1'b0;
  logic        kill8 = 1'b0;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8, zero8;
  logic [7:0]  result8;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] sb[$];
  logic        chk_en = 1'b0;
  logic        mbusy = 1'b0;
  logic        exp_done = 1'b0;
  int unsigned mleft = 0;
  logic [31:0] m_result = '0;

  muldiv_unit u_dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  muldiv_unit #(.XLEN(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .kill(kill8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .zero(zero8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_muldiv(input logic [2:0] f, input logic [31:0] x,
                                             input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     p;
    logic [31:0]     r;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (f)
      3'd0: begin p = sx * sy; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * longint'(uy); r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: begin
        if (y == 0) r = '1;
        else if (x == 32'h8000_0000 && y == '1) r = x;
        else begin p = sx / sy; r = p[31:0]; end
      end
      3'd5: r = (y == 0) ? '1 : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else begin p = sx % sy; r = p[31:0]; end
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  // Model of the handshake, evaluated on the same edges the DUT samples.
  always @(posedge clk) begin
    exp_done = 1'b0;
    if (rst) begin
      mbusy    = 1'b0;
      mleft    = 0;
      m_result = '0;
      sb.delete();
    end else if (mbusy) begin
      if (kill) begin
        mbusy = 1'b0;
        if (sb.size() > 0) sb.delete(0);
      end else begin
        mleft--;
        if (mleft == 0) begin
          mbusy    = 1'b0;
          exp_done = 1'b1;
          if (sb.size() > 0) m_result = sb.pop_front();
        end
      end
    end else if (start && !kill) begin
      mbusy = 1'b1;
      mleft = XLEN + 1;
      sb.push_back(ref_muldiv(op, a, b));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, mbusy);
      check("done", done, exp_done);
      check("result", result, m_result);
      check("zero", zero, m_result == 0);
    end
  end

  task automatic wait_idle();
    int unsigned n = 0;
    while (mbusy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n >= 100, 1'b0);
  endtask

  // Drive at a negedge; scramble operands after the accept edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    op = f; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    issue(f, x, y);
    wait_idle();
  endtask

  task automatic run8(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] expv);
    int unsigned lat = 0;
    op8 = f; a8 = x; b8 = y; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("lat8", lat, 9);
    check("res8", result8, expv);
    check("zero8", zero8, expv == 0);
    check("busy8", busy8, 1'b0);
  endtask

  function automatic logic [31:0] pick(input int unsigned sel);
    logic [31:0] r;
    case (sel)
      0: r = '0;
      1: r = 32'h8000_0000;
      2: r = '1;
      3: r = $urandom_range(0, 20);
      default: r = $urandom;
    endcase
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'hFFFF_FFFE, 32'd1);
    run_op(3'd7, 32'd10, 32'd3);
    run_op(3'd6, 32'd6, 32'd3);
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd6, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int unsigned i = 0; i < 70; i++) begin
      op = 3'($urandom);
      a = pick($urandom_range(0, 5));
      b = pick($urandom_range(0, 5));
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    repeat (3) @(negedge clk);

    issue(3'd4, 32'd100, 32'd7);
    repeat (32) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    repeat (2) @(negedge clk);

    start = 1'b1; kill = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    repeat (3) @(negedge clk);

    run_op(3'd0, 32'd9, 32'd9);
    issue(3'd3, 32'hDEAD_BEEF, 32'h1357_9BDF);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    for (int unsigned i = 0; i < 30; i++)
      run_op(3'($urandom), pick($urandom_range(0, 6)), pick($urandom_range(0, 6)));

    run8(3'd1, 8'h80, 8'h80, 8'h40);
    run8(3'd4, 8'h80, 8'hFF, 8'h80);
    run8(3'd3, 8'hFF, 8'hFF, 8'hFE);
    run8(3'd6, 8'hF9, 8'h02, 8'hFF);
    run8(3'd7, 8'h06, 8'h03, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
